solitaire_move_ctrl: RTL and testbench

- Sequences player input into single-cycle move commands for the peg solitaire board datapath (inputs piece_x/piece_y/direction; outputs piece_count/game_over).
- Conditions raw buttons, keeps a cursor restricted to existing board spaces, and arms a move on select. It then issues the move for exactly one cycle and classifies it as accepted or rejected.
- Sits between the Tiny Tapeout IO pins and the board instance.

---
 rtl/solitaire_pkg.sv | 53 +++++
 rtl/solitaire_move_ctrl_if.sv | 20 ++
 rtl/solitaire_btn_cond.sv | 48 ++++
 rtl/solitaire_move_ctrl.sv | 144 ++++++++++++++
 tb/tb_solitaire_move_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/solitaire_pkg.sv
// Shared types and board geometry for the peg solitaire move controller.
// Contents:
//   BOARD_WIDTH   side length of the square bounding the cross-shaped board
//   PARK_COORD    coordinate value that matches no square
//   dir_t         move direction codes used on the board bus
//   ctrl_state_t  controller FSM states
//   space_exists  true when (x,y) is a real board space
//   step_xy       cursor displacement helper (3-bit wrap; off-board results are
//                 caught by space_exists)
package solitaire_pkg;

  localparam int unsigned BOARD_WIDTH = 7;
  localparam logic [2:0]  PARK_COORD  = 3'd7;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    CURSOR,
    ARMED,
    ISSUE,
    CHECK,
    DONE
  } ctrl_state_t;

  function automatic logic space_exists(input logic [2:0] x, input logic [2:0] y);
    logic on_square;
    logic in_cross;
    on_square = (32'(x) < BOARD_WIDTH) && (32'(y) < BOARD_WIDTH);
    in_cross  = (x >= 3'd2 && x <= 3'd4) || (y >= 3'd2 && y <= 3'd4);
    return on_square && in_cross;
  endfunction

  function automatic logic [5:0] step_xy(input logic [2:0] x, input logic [2:0] y,
                                         input dir_t d, input logic [2:0] n);
    logic [2:0] nx;
    logic [2:0] ny;
    nx = x;
    ny = y;
    case (d)
      LEFT:    nx = x - n;
      RIGHT:   nx = x + n;
      UP:      ny = y - n;
      default: ny = y + n;
    endcase
    return {nx, ny};
  endfunction

endpackage

// File: rtl/solitaire_move_ctrl_if.sv
// Bus between the move controller and the peg solitaire board.
//   piece_x, piece_y  move source coordinates (PARK_COORD when idle)
//   direction         move direction
//   piece_count       current peg count reported by the board
//   game_over         board reports no legal move remains
// master: controller side, slave: board side.
interface solitaire_move_ctrl_if;
  import solitaire_pkg::*;

  logic [2:0] piece_x;
  logic [2:0] piece_y;
  dir_t       direction;
  logic [5:0] piece_count;
  logic       game_over;

  modport master (output piece_x, piece_y, direction,
                  input  piece_count, game_over);
  modport slave  (input  piece_x, piece_y, direction,
                  output piece_count, game_over);
endinterface

// File: rtl/solitaire_btn_cond.sv
// Button conditioner: synchronizer chain, debounce counter, rising-edge event.
//   clk, rst_n  clock and async active-low reset
//   btn         raw asynchronous button, active-high
//   press       one-cycle pulse when the debounced level goes 0->1
// The accepted level flips after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the count.
module solitaire_btn_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      press <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sample;
        cnt   <= '0;
        press <= sample;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/solitaire_move_ctrl.sv
// Peg solitaire move controller: turns debounced buttons into single-cycle
// move commands for the board and classifies the result.
//   clk, rst_n                        clock, async active-low reset
//   btn_up/down/left/right/sel/cancel raw buttons, active-high
//   board (master)                    piece_x/piece_y/direction out,
//                                     piece_count/game_over in
//   cursor_x, cursor_y                cursor position
//   armed                             waiting for a move direction
//   move_ok, move_rej                 one-cycle result pulses
//   done                              latched end of game
module solitaire_move_ctrl
  import solitaire_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_sel,
  input  logic                         btn_cancel,
  solitaire_move_ctrl_if.master        board,
  output logic [2:0]                   cursor_x,
  output logic [2:0]                   cursor_y,
  output logic                         armed,
  output logic                         move_ok,
  output logic                         move_rej,
  output logic                         done
);

  localparam int unsigned EV_UP     = 0;
  localparam int unsigned EV_DOWN   = 1;
  localparam int unsigned EV_LEFT   = 2;
  localparam int unsigned EV_RIGHT  = 3;
  localparam int unsigned EV_SEL    = 4;
  localparam int unsigned EV_CANCEL = 5;

  logic [5:0]  raw;
  logic [5:0]  ev;
  ctrl_state_t state;
  dir_t        dir_lat;
  dir_t        ev_dir;
  logic        dir_any;
  logic [5:0]  cnt_snap;
  logic        count_ok;
  logic [2:0]  step_x, step_y;
  logic [2:0]  jump_x, jump_y;

  assign raw = {btn_cancel, btn_sel, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 6; i++) begin : g_btn
    solitaire_btn_cond #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .press(ev[i])
    );
  end

  always_comb begin
    ev_dir  = LEFT;
    dir_any = 1'b1;
    if      (ev[EV_UP])    ev_dir = UP;
    else if (ev[EV_DOWN])  ev_dir = DOWN;
    else if (ev[EV_LEFT])  ev_dir = LEFT;
    else if (ev[EV_RIGHT]) ev_dir = RIGHT;
    else                   dir_any = 1'b0;
    {step_x, step_y} = step_xy(cursor_x, cursor_y, ev_dir, 3'd1);
    {jump_x, jump_y} = step_xy(cursor_x, cursor_y, dir_lat, 3'd2);
  end

  // The board commits the move on the edge that ends ISSUE, so the new
  // piece_count only exists during CHECK; the result pulses are decoded from
  // the CHECK state so they land in that same cycle.
  assign count_ok = (board.piece_count == cnt_snap - 6'd1);
  assign move_ok  = (state == CHECK) &&  count_ok;
  assign move_rej = (state == CHECK) && !count_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CURSOR;
      cursor_x        <= 3'd3;
      cursor_y        <= 3'd3;
      armed           <= 1'b0;
      done            <= 1'b0;
      dir_lat         <= LEFT;
      cnt_snap        <= '0;
      board.piece_x   <= PARK_COORD;
      board.piece_y   <= PARK_COORD;
      board.direction <= LEFT;
    end else begin
      case (state)
        CURSOR: begin
          if (board.game_over) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (ev[EV_SEL]) begin
            state <= ARMED;
            armed <= 1'b1;
          end else if (dir_any && space_exists(step_x, step_y)) begin
            cursor_x <= step_x;
            cursor_y <= step_y;
          end
        end
        ARMED: begin
          if (ev[EV_CANCEL] || ev[EV_SEL]) begin
            state <= CURSOR;
            armed <= 1'b0;
          end else if (dir_any) begin
            state           <= ISSUE;
            armed           <= 1'b0;
            dir_lat         <= ev_dir;
            board.piece_x   <= cursor_x;
            board.piece_y   <= cursor_y;
            board.direction <= ev_dir;
          end
        end
        ISSUE: begin
          cnt_snap        <= board.piece_count;
          board.piece_x   <= PARK_COORD;
          board.piece_y   <= PARK_COORD;
          board.direction <= LEFT;
          state           <= CHECK;
        end
        CHECK: begin
          if (count_ok) begin
            cursor_x <= jump_x;
            cursor_y <= jump_y;
          end
          state <= CURSOR;
        end
        DONE: state <= DONE;
        default: state <= CURSOR;
      endcase
    end
  end

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
module tb_solitaire_move_ctrl;

  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int HOLD   = SYNC + DEB + 3;
  localparam int SETTLE = SYNC + DEB + 6;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel;
  logic [2:0] cursor_x, cursor_y;
  logic armed, move_ok, move_rej, done;

  solitaire_move_ctrl_if bus();

  solitaire_move_ctrl #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .btn_cancel(btn_cancel),
    .board     (bus),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .armed     (armed),
    .move_ok   (move_ok),
    .move_rej  (move_rej),
    .done      (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference board (also acts as the board slave) --------
  int dxs[4] = '{-1, 1, 0, 0};   // LEFT, RIGHT, UP, DOWN
  int dys[4] = '{0, 0, -1, 1};
  bit brd [7][7];

  function automatic bit on_board(input int x, input int y);
    if (x < 0 || x > 6 || y < 0 || y > 6) return 1'b0;
    return !((x < 2 || x > 4) && (y < 2 || y > 4));
  endfunction

  function automatic bit legal(input int x, input int y, input int d);
    int jx, jy, lx, ly;
    jx = x + dxs[d];     jy = y + dys[d];
    lx = x + 2 * dxs[d]; ly = y + 2 * dys[d];
    if (!on_board(x, y) || !on_board(jx, jy) || !on_board(lx, ly)) return 1'b0;
    return brd[x][y] && brd[jx][jy] && !brd[lx][ly];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < 7; x++)
        for (int y = 0; y < 7; y++)
          brd[x][y] <= on_board(x, y) && !(x == 3 && y == 3);
      bus.piece_count <= 6'd32;
    end else if (bus.piece_x != 3'd7 &&
                 legal(int'(bus.piece_x), int'(bus.piece_y), int'(bus.direction))) begin
      int x, y, d;
      x = int'(bus.piece_x); y = int'(bus.piece_y); d = int'(bus.direction);
      brd[x][y] <= 1'b0;
      brd[x + dxs[d]][y + dys[d]] <= 1'b0;
      brd[x + 2 * dxs[d]][y + 2 * dys[d]] <= 1'b1;
      bus.piece_count <= bus.piece_count - 6'd1;
    end
  end

  // ---------------- controller reference model + scoreboard ---------------
  typedef struct { int x; int y; int d; int ok; } mv_t;
  mv_t exp_q[$];
  int  cx = 3, cy = 3;
  bit  m_armed = 1'b0;

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 sel, 5 cancel
  task automatic model(input logic [5:0] m);
    int d;
    int ok;
    d = -1;
    if      (m[0]) d = 2;
    else if (m[1]) d = 3;
    else if (m[2]) d = 0;
    else if (m[3]) d = 1;
    if (!m_armed) begin
      if (m[4]) m_armed = 1'b1;
      else if (d >= 0 && on_board(cx + dxs[d], cy + dys[d])) begin
        cx += dxs[d];
        cy += dys[d];
      end
    end else begin
      if (m[5] || m[4]) m_armed = 1'b0;
      else if (d >= 0) begin
        ok = int'(legal(cx, cy, d));
        exp_q.push_back('{cx, cy, d, ok});
        if (ok != 0) begin
          cx += 2 * dxs[d];
          cy += 2 * dys[d];
        end
        m_armed = 1'b0;
      end
    end
  endtask

  task automatic set_btns(input logic [5:0] m);
    {btn_cancel, btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic drive(input logic [5:0] m);
    set_btns(m);
    repeat (HOLD) @(negedge clk);
    set_btns(6'd0);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] m);
    model(m);
    drive(m);
    check("cursor_x", int'(cursor_x), cx);
    check("cursor_y", int'(cursor_y), cy);
    check("armed", int'(armed), int'(m_armed));
  endtask

  // ---------------- monitor ------------------------------------------------
  int iss_x, iss_y, iss_d;
  bit iss_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      iss_prev = 1'b0;
    end else begin
      if (move_ok || move_rej) begin
        mv_t e;
        check("pulse_after_issue", int'(iss_prev), 1);
        check("pulse_parked", int'({bus.piece_x, bus.piece_y, bus.direction}), 252);
        check("pulse_exclusive", int'(move_ok & move_rej), 0);
        if (exp_q.size() == 0) begin
          check("pulse_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("move_x", iss_x, e.x);
          check("move_y", iss_y, e.y);
          check("move_dir", iss_d, e.d);
          check("move_ok", int'(move_ok), e.ok);
        end
      end
      if (bus.piece_x != 3'd7 || bus.piece_y != 3'd7) begin
        check("issue_single_cycle", int'(iss_prev), 0);
        check("issue_armed_low", int'(armed), 0);
        iss_x = int'(bus.piece_x);
        iss_y = int'(bus.piece_y);
        iss_d = int'(bus.direction);
        iss_prev = 1'b1;
      end else begin
        iss_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus -----------------------------------------------
  initial begin
    int sx, sy, r, fd;
    logic [5:0] m;
    rst_n = 1'b1;
    set_btns(6'd0);
    bus.game_over = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    check("rst_cursor_x", int'(cursor_x), 3);
    check("rst_cursor_y", int'(cursor_y), 3);
    check("rst_piece_x", int'(bus.piece_x), 7);
    check("rst_piece_y", int'(bus.piece_y), 7);
    check("rst_direction", int'(bus.direction), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_move_ok", int'(move_ok), 0);
    check("rst_move_rej", int'(move_rej), 0);
    check("rst_done", int'(done), 0);
    check("rst_piece_count", int'(bus.piece_count), 32);

    // raw edge -> event takes SYNC+DEB cycles, the FSM acts one edge later
    btn_up = 1'b1;
    repeat (SYNC + DEB) @(negedge clk);
    check("latency_before", int'(cursor_y), 3);
    @(negedge clk);
    check("latency_after", int'(cursor_y), 2);
    btn_up = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model(6'b000001);

    press(6'b000001);                 // (3,1)
    press(6'b000001);                 // (3,0)
    press(6'b000001);                 // off board, stays (3,0)
    press(6'b000100);                 // (2,0)
    press(6'b000100);                 // (1,0) missing, stays (2,0)
    press(6'b001000);                 // (3,0)
    press(6'b000010);                 // (3,1)
    press(6'b010000);                 // armed
    press(6'b000010);                 // jump down onto (3,3)
    check("legal_cursor", cx * 10 + cy, 33);
    check("legal_piece_count", int'(bus.piece_count), 31);
    press(6'b010000);
    press(6'b000001);                 // (3,2) now empty: rejected
    check("rej_piece_count", int'(bus.piece_count), 31);
    press(6'b010000);
    press(6'b100000);                 // cancel back to CURSOR
    press(6'b010101);                 // sel wins over up/left: armed
    press(6'b010000);                 // sel disarms

    // bounce shorter than the debounce window must not move the cursor
    btn_right = 1'b1; @(negedge clk);
    btn_right = 1'b0; @(negedge clk);
    btn_right = 1'b1; @(negedge clk);
    btn_right = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("bounce_cursor_x", int'(cursor_x), cx);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      m = 6'(1 << r);
      else if (r <= 5) m = 6'b010000;
      else if (r == 6) m = 6'b100000;
      else if (r == 7) m = 6'($urandom_range(1, 63));
      else if (r == 8) m = 6'(1 << $urandom_range(0, 3));
      else begin
        m = 6'd0;
        fd = -1;
        for (int d = 0; d < 4; d++)
          if (fd < 0 && legal(cx, cy, d)) fd = d;
        if (fd >= 0 && !m_armed) begin
          press(6'b010000);
          m = (fd == 0) ? 6'b000100 : (fd == 1) ? 6'b001000 :
              (fd == 2) ? 6'b000001 : 6'b000010;
        end
      end
      if (m != 6'd0) press(m);
    end
    check("queue_drained", exp_q.size(), 0);

    if (m_armed) press(6'b100000);
    bus.game_over = 1'b1;
    @(negedge clk);
    check("done_set", int'(done), 1);
    bus.game_over = 1'b0;
    sx = cx; sy = cy;
    drive(6'b010000);
    drive(6'b000001);
    drive(6'b001000);
    check("done_cursor_x", int'(cursor_x), sx);
    check("done_cursor_y", int'(cursor_y), sy);
    check("done_armed", int'(armed), 0);
    check("done_held", int'(done), 1);

    #2 rst_n = 1'b0;
    #1;
    check("async_cursor_x", int'(cursor_x), 3);
    check("async_cursor_y", int'(cursor_y), 3);
    check("async_done", int'(done), 0);
    check("async_piece_x", int'(bus.piece_x), 7);
    @(negedge clk);
    rst_n = 1'b1;
    cx = 3; cy = 3; m_armed = 1'b0;
    repeat (5) @(negedge clk);
    press(6'b000001);
    check("post_reset_done", int'(done), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
